// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and digit-validity helper
package bcd_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_ZERO  = 4'd0;
  // active-low segment code with every segment off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic is_bcd(input logic [3:0] value);
    return value <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD digit with sanitising load and carry/borrow ripple
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step_in,
  input  logic       up,
  output logic [3:0] digit,
  output logic       step_out
);

  logic at_limit;

  assign at_limit = up ? (digit == BCD_MAX) : (digit == BCD_ZERO);
  assign step_out = step_in & at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= is_bcd(load_digit) ? load_digit : BCD_ZERO;
    end else if (step_in) begin
      if (at_limit)
        digit <= up ? BCD_ZERO : BCD_MAX;
      else
        digit <= up ? digit + 4'd1 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD up/down counter with prescaled tick and pushbutton step
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESETn,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  input  logic                  STEP_n,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  TC,
  output logic                  TICK
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]   ps_cnt;
  logic            step_sync1;
  logic            step_sync2;
  logic            step_hist;
  logic            fill1;
  logic            fill2;
  logic            step_armed;
  logic            step;
  logic [DIGITS:0] carry;

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn)
      ps_cnt <= '0;
    else if (!EN || ps_cnt == PS_LAST)
      ps_cnt <= '0;
    else
      ps_cnt <= ps_cnt + PW'(1);
  end

  assign TICK = EN & (ps_cnt == PS_LAST);

  // step is only armed once a real synchronised sample shows the button idle,
  // so a press held across reset release never counts
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      step_sync1 <= 1'b1;
      step_sync2 <= 1'b1;
      step_hist  <= 1'b1;
      fill1      <= 1'b0;
      fill2      <= 1'b0;
      step_armed <= 1'b0;
    end else begin
      step_sync1 <= STEP_n;
      step_sync2 <= step_sync1;
      step_hist  <= step_sync2;
      fill1      <= 1'b1;
      fill2      <= fill1;
      step_armed <= step_armed | (fill2 & step_sync2);
    end
  end

  assign step     = step_armed & step_hist & ~step_sync2;
  assign carry[0] = (TICK | step) & ~LOAD;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (CLOCK_50),
      .rst_n      (RESETn),
      .load       (LOAD),
      .load_digit (LOAD_VAL[4*g +: 4]),
      .step_in    (carry[g]),
      .up         (UP),
      .digit      (BCD[4*g +: 4]),
      .step_out   (carry[g+1])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn)
      TC <= 1'b0;
    else
      TC <= carry[DIGITS];
  end

endmodule
